ram_port_arbiter: RTL

Two-requester arbiter for the read/write port (port 1) of the dual-ported word RAM. It shares that port between the CPU data-memory interface (m0) and a second bus master such as the firmware loader or debug/DMA path (m1). Requests use a req/ack handshake. The arbiter latches the winning request and drives the RAM for exactly one cycle, then returns read data with a one-cycle ack. Port 2 (instruction fetch) is not touched by this block.

---
 rtl/ram_port_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// ram_port_arbiter : round-robin req/ack arbiter sharing RAM port 1 between
//                    two bus masters (one access per three cycles).
// Revision 1.0
// ============================================================================
`default_nettype none

module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [31:0]           m0_wdata_i,
  input  logic [3:0]            m0_wstrb_i,
  output logic                  m0_ack_o,
  output logic [31:0]           m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [31:0]           m1_wdata_i,
  input  logic [3:0]            m1_wstrb_i,
  output logic                  m1_ack_o,
  output logic [31:0]           m1_rdata_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  output logic [3:0]            ram_wenable_o,
  input  logic [31:0]           ram_rdata_i,
  output logic                  busy_o,
  output logic                  owner_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [31:0]           m0_rdata_q, m1_rdata_q;
  logic                  w_grant;

  // owner_q doubles as the winner of the transaction in flight
  assign w_grant = (m0_req_i && m1_req_i) ? ~owner_q : m1_req_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          state_d = ACCESS;
          owner_d = w_grant;
          addr_d  = w_grant ? m1_addr_i  : m0_addr_i;
          wdata_d = w_grant ? m1_wdata_i : m0_wdata_i;
          wstrb_d = w_grant ? m1_wstrb_i : m0_wstrb_i;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      if (state_q == ACCESS) begin
        if (owner_q) m1_rdata_q <= ram_rdata_i;
        else         m0_rdata_q <= ram_rdata_i;
      end
    end
  end

  // Strobes come straight from the state register so reset kills a write at once
  assign ram_wenable_o = (state_q == ACCESS) ? wstrb_q : 4'b0000;
  assign ram_addr_o    = addr_q;
  assign ram_wdata_o   = wdata_q;
  assign m0_ack_o      = (state_q == RESP) && !owner_q;
  assign m1_ack_o      = (state_q == RESP) &&  owner_q;
  assign m0_rdata_o    = m0_rdata_q;
  assign m1_rdata_o    = m1_rdata_q;
  assign busy_o        = (state_q != IDLE);
  assign owner_o       = owner_q;

endmodule

`default_nettype wire
